// File: rtl/llmint_tiled_matvec_if.sv
// Vector / weight-row / result handshake bundle for llmint_tiled_matvec.
// The master drives operands and result-ready; the slave is the block itself.
interface llmint_tiled_matvec_if #(
    parameter int ORIGINAL_PRECISION = 16,
    parameter int TENSOR_SIZE_DIM    = 4
);
    localparam int CW = $clog2(TENSOR_SIZE_DIM + 1);

    logic                                                force_high;
    logic [TENSOR_SIZE_DIM-1:0][ORIGINAL_PRECISION-1:0]  data_in;
    logic                                                data_in_valid;
    logic                                                data_in_ready;
    logic [TENSOR_SIZE_DIM-1:0][ORIGINAL_PRECISION-1:0]  weight;
    logic                                                weight_valid;
    logic                                                weight_ready;
    logic [ORIGINAL_PRECISION-1:0]                       data_out;
    logic                                                data_out_last;
    logic [CW-1:0]                                       outlier_count;
    logic                                                data_out_valid;
    logic                                                data_out_ready;

    modport master (
        output force_high, data_in, data_in_valid, weight, weight_valid, data_out_ready,
        input  data_in_ready, weight_ready, data_out, data_out_last, outlier_count, data_out_valid
    );

    modport slave (
        input  force_high, data_in, data_in_valid, weight, weight_valid, data_out_ready,
        output data_in_ready, weight_ready, data_out, data_out_last, outlier_count, data_out_valid
    );
endinterface

// File: rtl/llmint_tiled_matvec.sv
// Outlier-split mat-vec: one latched activation vector, OUT_DIM streamed weight rows,
// one saturated result per row. Outlier columns run full precision, the rest quantized.
module llmint_tiled_matvec_lane #(
    parameter int O = 16,
    parameter int R = 8
) (
    input  logic [O-1:0]   x,
    input  logic [O-1:0]   w,
    output logic [2*O-1:0] hp,
    output logic [2*R-1:0] lp
);
    logic signed [2*O-1:0] xe, we;
    logic signed [2*R-1:0] xqe, wqe;

    assign xe  = {{O{x[O-1]}}, x};
    assign we  = {{O{w[O-1]}}, w};
    // Top R bits are exactly x >>> (O-R), truncated to the reduced width.
    assign xqe = {{R{x[O-1]}}, x[O-1:O-R]};
    assign wqe = {{R{w[O-1]}}, w[O-1:O-R]};
    assign hp  = xe * we;
    assign lp  = xqe * wqe;
endmodule

module llmint_tiled_matvec #(
    parameter int ORIGINAL_PRECISION = 16,
    parameter int REDUCED_PRECISION  = 8,
    parameter int TENSOR_SIZE_DIM    = 4,
    parameter int OUT_DIM            = 4,
    parameter int HIGH_SLOTS         = 2,
    parameter int THRESHOLD          = 6,
    parameter int OUT_SHIFT          = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    llmint_tiled_matvec_if.slave bus
);
    localparam int O  = ORIGINAL_PRECISION;
    localparam int R  = REDUCED_PRECISION;
    localparam int N  = TENSOR_SIZE_DIM;
    localparam int AW = 2*O + $clog2(N) + 1;
    localparam int CW = $clog2(N + 1);
    localparam int RW = $clog2(OUT_DIM + 1);
    localparam int SH = 2*(O - R);

    localparam logic signed [O:0]    TH      = (O+1)'(THRESHOLD);
    localparam logic [CW-1:0]        HS      = CW'(HIGH_SLOTS);
    localparam logic [RW-1:0]        LAST    = RW'(OUT_DIM - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-O+1){1'b0}}, {(O-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-O+1){1'b1}}, {(O-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ROWS, DRAIN} state_t;
    typedef struct packed {
        logic [O-1:0] data;
        logic         last;
    } res_t;

    state_t              state;
    logic [N-1:0][O-1:0] x_q;
    logic [N-1:0]        mask_q, mask_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [RW-1:0]       row_cnt;
    res_t                res_q;
    logic                out_vld, in_rdy;
    logic                w_acc;

    logic [N-1:0][2*O-1:0] hp;
    logic [N-1:0][2*R-1:0] lp;
    logic signed [AW-1:0]  acc_hi, acc_lo, sum, shr;
    logic [O-1:0]          sat;

    assign bus.data_in_ready  = in_rdy;
    assign bus.weight_ready   = (state == ROWS) && (!out_vld || bus.data_out_ready);
    assign bus.data_out       = res_q.data;
    assign bus.data_out_last  = res_q.last;
    assign bus.data_out_valid = out_vld;
    assign bus.outlier_count  = cnt_q;
    assign w_acc              = bus.weight_valid && bus.weight_ready;

    // First HIGH_SLOTS outliers in column order take the full-precision path.
    always_comb begin
        mask_d = '0;
        cnt_d  = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.force_high ||
                ((($signed(bus.data_in[i]) > TH) || ($signed(bus.data_in[i]) < -TH)) && (cnt_d < HS))) begin
                mask_d[i] = 1'b1;
                cnt_d     = cnt_d + CW'(1);
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        llmint_tiled_matvec_lane #(.O(O), .R(R)) u_lane (
            .x  (x_q[i]),
            .w  (bus.weight[i]),
            .hp (hp[i]),
            .lp (lp[i])
        );
    end

    always_comb begin
        acc_hi = '0;
        acc_lo = '0;
        for (int i = 0; i < N; i++) begin
            if (mask_q[i]) acc_hi = acc_hi + {{(AW-2*O){hp[i][2*O-1]}}, hp[i]};
            else           acc_lo = acc_lo + {{(AW-2*R){lp[i][2*R-1]}}, lp[i]};
        end
        sum = acc_hi + (acc_lo <<< SH);
        shr = sum >>> OUT_SHIFT;
        if (shr > SAT_MAX)      sat = {1'b0, {(O-1){1'b1}}};
        else if (shr < SAT_MIN) sat = {1'b1, {(O-1){1'b0}}};
        else                    sat = shr[O-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            in_rdy  <= 1'b1;
            x_q     <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            row_cnt <= '0;
            res_q   <= '0;
            out_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.data_in_valid) begin
                    x_q     <= bus.data_in;
                    mask_q  <= mask_d;
                    cnt_q   <= cnt_d;
                    row_cnt <= '0;
                    in_rdy  <= 1'b0;
                    state   <= ROWS;
                end
                ROWS: begin
                    if (w_acc) begin
                        res_q   <= '{data: sat, last: (row_cnt == LAST)};
                        out_vld <= 1'b1;
                        row_cnt <= row_cnt + RW'(1);
                        if (row_cnt == LAST) state <= DRAIN;
                    end else if (out_vld && bus.data_out_ready) begin
                        out_vld    <= 1'b0;
                        res_q.last <= 1'b0;
                    end
                end
                DRAIN: if (out_vld && bus.data_out_ready) begin
                    out_vld    <= 1'b0;
                    res_q.last <= 1'b0;
                    in_rdy     <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_llmint_tiled_matvec.sv
// Directed bench for llmint_tiled_matvec: split, slot limit, force_high, backpressure,
// mid-vector reset and negative saturation, with hand-computed expectations.
module tb_llmint_tiled_matvec;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    llmint_tiled_matvec_if #(.ORIGINAL_PRECISION(16), .TENSOR_SIZE_DIM(4)) bus ();

    llmint_tiled_matvec #(
        .ORIGINAL_PRECISION(16), .REDUCED_PRECISION(8), .TENSOR_SIZE_DIM(4),
        .OUT_DIM(4), .HIGH_SLOTS(2), .THRESHOLD(6), .OUT_SHIFT(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [3:0][15:0] vec(input int a, input int b, input int c, input int d);
        logic [3:0][15:0] v;
        v[0] = 16'(a);
        v[1] = 16'(b);
        v[2] = 16'(c);
        v[3] = 16'(d);
        return v;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_vec(input logic [3:0][15:0] x, input logic fh, input int exp_cnt);
        int n;
        @(negedge clk);
        bus.data_in       = x;
        bus.force_high    = fh;
        bus.data_in_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.data_in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("vec_ready", bus.data_in_ready, 1);
        @(negedge clk);
        bus.data_in_valid = 1'b0;
        #1;
        chk("wready_after_vec", bus.weight_ready, 1);
        chk("inrdy_in_rows", bus.data_in_ready, 0);
        chk("outlier_count", bus.outlier_count, exp_cnt);
    endtask

    task automatic send_row(input string tag, input logic [3:0][15:0] w, input int exp, input logic exp_last);
        int n;
        @(negedge clk);
        bus.weight       = w;
        bus.weight_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.weight_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_wready"}, bus.weight_ready, 1);
        @(negedge clk);
        bus.weight_valid = 1'b0;
        #1;
        chk({tag, "_valid"}, bus.data_out_valid, 1);
        chk({tag, "_data"}, $signed(bus.data_out), exp);
        chk({tag, "_last"}, bus.data_out_last, exp_last);
    endtask

    initial begin
        bus.force_high     = 1'b0;
        bus.data_in        = '0;
        bus.data_in_valid  = 1'b0;
        bus.weight         = '0;
        bus.weight_valid   = 1'b0;
        bus.data_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", bus.data_out_valid, 0);
        chk("rst_data", $signed(bus.data_out), 0);
        chk("rst_last", bus.data_out_last, 0);
        chk("rst_count", bus.outlier_count, 0);
        chk("rst_inrdy", bus.data_in_ready, 1);
        chk("rst_wready", bus.weight_ready, 0);

        // Weight rows offered in IDLE must be ignored.
        @(negedge clk);
        bus.weight       = vec(1, 1, 1, 1);
        bus.weight_valid = 1'b1;
        #1;
        chk("idle_wready", bus.weight_ready, 0);
        @(negedge clk);
        #1;
        chk("idle_no_result", bus.data_out_valid, 0);
        bus.weight_valid = 1'b0;

        // Basic split
        send_vec(vec(1, 100, -200, 3), 1'b0, 2);
        send_row("basic0", vec(1, 1, 1, 1), -100, 1'b0);
        send_row("basic1", vec(1, 1, 1, 1), -100, 1'b0);
        send_row("basic2", vec(1, 1, 1, 1), -100, 1'b0);
        send_row("basic3", vec(1, 1, 1, 1), -100, 1'b1);

        // Slot limit and saturation
        send_vec(vec(512, 7, -8, 256), 1'b0, 2);
        send_row("slot0", vec(256, 256, 256, 256), 32767, 1'b0);
        send_row("slot1", vec(1, 1, 1, 1), 519, 1'b0);
        send_row("slot2", vec(0, 0, 0, -256), -32768, 1'b0);
        send_row("slot3", vec(-1, -1, -1, -1), -519, 1'b1);

        // force_high
        send_vec(vec(512, 7, -8, 256), 1'b1, 4);
        send_row("force0", vec(1, 1, 1, 1), 767, 1'b0);
        send_row("force1", vec(2, 0, 0, 0), 1024, 1'b0);
        send_row("force2", vec(0, 0, 0, 0), 0, 1'b0);
        send_row("force3", vec(0, 0, -1, 0), 8, 1'b1);

        // Backpressure on row 1
        send_vec(vec(1, 100, -200, 3), 1'b0, 2);
        @(negedge clk);
        bus.weight       = vec(1, 1, 1, 1);
        bus.weight_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("bp0_data", $signed(bus.data_out), -100);
        bus.weight = vec(0, 1, 0, 0);
        @(negedge clk);
        #1;
        chk("bp1_data", $signed(bus.data_out), 100);
        chk("bp1_valid", bus.data_out_valid, 1);
        bus.data_out_ready = 1'b0;
        bus.weight         = vec(0, 0, 1, 0);
        #1;
        chk("bp_wready_low0", bus.weight_ready, 0);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("bp_wready_low", bus.weight_ready, 0);
            chk("bp_hold_data", $signed(bus.data_out), 100);
            chk("bp_hold_valid", bus.data_out_valid, 1);
            chk("bp_hold_last", bus.data_out_last, 0);
        end
        bus.data_out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp2_data", $signed(bus.data_out), -200);
        chk("bp2_last", bus.data_out_last, 0);
        bus.weight = vec(0, 2, 0, 0);
        @(negedge clk);
        bus.weight_valid = 1'b0;
        #1;
        chk("bp3_data", $signed(bus.data_out), 200);
        chk("bp3_last", bus.data_out_last, 1);
        chk("bp_drain_wready", bus.weight_ready, 0);
        chk("bp_drain_inrdy", bus.data_in_ready, 0);
        @(negedge clk);
        #1;
        chk("bp_inrdy_back", bus.data_in_ready, 1);
        chk("bp_valid_clear", bus.data_out_valid, 0);

        // Reset mid-vector
        send_vec(vec(1, 100, -200, 3), 1'b0, 2);
        send_row("abort0", vec(1, 1, 1, 1), -100, 1'b0);
        send_row("abort1", vec(0, 1, 0, 0), 100, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_valid", bus.data_out_valid, 0);
        chk("abort_inrdy", bus.data_in_ready, 1);
        chk("abort_wready", bus.weight_ready, 0);
        chk("abort_count", bus.outlier_count, 0);
        chk("abort_data", $signed(bus.data_out), 0);

        // Negative boundary
        send_vec(vec(-32768, 0, 0, 0), 1'b0, 1);
        send_row("neg0", vec(-1, 0, 0, 0), 32767, 1'b0);
        send_row("neg1", vec(1, 0, 0, 0), -32768, 1'b0);
        send_row("neg2", vec(0, 5, 0, 0), 0, 1'b0);
        send_row("neg3", vec(2, 0, 0, 0), -32768, 1'b1);
        @(negedge clk);
        #1;
        chk("neg_inrdy_back", bus.data_in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
